msu_job_driver: RTL and testbench
=================================

// Module: msu_job_driver
// PURPOSE
//  Host-side counterpart of the MSU AXI-stream engine. Accepts one parallel job
//  (t_start, t_final, sq_in), serializes it onto an AXI-stream master and pulses
//  ap_start. It then collects the result stream (t_current, sq_out), checks its
//  framing and presents the deserialized result on a valid/ready port.
//  Used in loopback benches and on-chip controllers that sit in front of the MSU.
// PARAMETERS
//  AXI_LEN        32    stream data width, bits
//  T_LEN          64    iteration-count width, multiple of AXI_LEN
//  SQ_IN_BITS     1024  modulus-size input width, multiple of AXI_LEN
//  SQ_OUT_BITS    1056  redundant output width, multiple of AXI_LEN
//  TIMEOUT_CYCLES 0     max idle cycles in SEND/RECV before abort; 0 = disabled
//  derived: IN_CNT = 2*T_LEN/AXI_LEN + SQ_IN_BITS/AXI_LEN (36); OUT_CNT = T_LEN/AXI_LEN + SQ_OUT_BITS/AXI_LEN (35)
// PORTS
//  clk            in   1            clock; all logic on rising edge
//  reset          in   1            synchronous, active-low reset
//  job_valid      in   1            job request
//  job_ready      out  1            high only in IDLE
//  job_t_start    in   T_LEN        starting iteration
//  job_t_final    in   T_LEN        final iteration
//  job_sq_in      in   SQ_IN_BITS   squarer input value
//  ap_start       out  1            one-cycle start pulse to MSU
//  m_axis_tvalid  out  1            job stream valid
//  m_axis_tready  in   1            job stream ready
//  m_axis_tdata   out  AXI_LEN      job stream data
//  m_axis_tkeep   out  AXI_LEN/8    all ones
//  m_axis_tlast   out  1            high on beat IN_CNT-1
//  s_axis_tvalid  in   1            result stream valid
//  s_axis_tready  out  1            high only in RECV
//  s_axis_tdata   in   AXI_LEN      result stream data
//  s_axis_tlast   in   1            result end marker
//  ap_done        in   1            MSU done pulse; sampled, not required
//  res_valid      out  1            result available
//  res_ready      in   1            result consumed
//  res_t          out  T_LEN        returned t_current
//  res_sq         out  SQ_OUT_BITS  returned sq_out
//  res_err        out  2            [0] framing error; [1] timeout; valid with res_valid
// BEHAVIOUR
//  - Reset (reset==0 at an edge): state IDLE. ap_start, m_axis_tvalid, m_axis_tlast,
//    s_axis_tready, res_valid, res_err are 0. Beat counters are 0. job_ready is 1
//    from the first cycle after reset. Reset mid-operation aborts immediately; no partial result is output.
//  - IDLE: job_valid&&job_ready latches {sq_in,t_final,t_start} into the shift register -> START.
//  - START: ap_start=1 for exactly this one cycle -> SEND on the next cycle.
//  - SEND: m_axis_tvalid=1. tdata = shift register LSW. Beat order is LSW first:
//    t_start words, then t_final words, then sq_in words.
//    Shift and count only when tvalid&&tready. tdata/tlast stay stable while stalled.
//    tlast = (count==IN_CNT-1). The handshake on the last beat -> RECV.
//  - RECV: s_axis_tready=1. On each tvalid&&tready, the word shifts in from the MSB side,
//    giving {sq_out,t_current} with LSW = first beat.
//    Beat OUT_CNT-1 -> RESULT; err[0] is set if tlast==0 on that beat.
//    tlast on any earlier beat -> RESULT with err[0]=1; res_t/res_sq then hold the partial data, right-aligned.
//  - RESULT: res_valid=1 and all res_* are stable until res_ready. The cycle with
//    res_valid&&res_ready -> IDLE, and res_valid drops on the next cycle.
//  - The s_axis_tready gate matters: the MSU advances its output on tready alone, so
//    s_axis_tready must never be high outside RECV.
//  - Timeout: when TIMEOUT_CYCLES>0, a counter clears on every handshake and on state
//    change. It increments on cycles in SEND/RECV with no handshake. Reaching
//    TIMEOUT_CYCLES -> RESULT with err[1]=1.
//  - ap_done is ignored for sequencing. A job_valid held high in RESULT is not accepted until IDLE.
//  - Widths: counters are $clog2(max(IN_CNT,OUT_CNT)+1) bits; no wrap is possible because states exit at terminal count.
// TESTING
//  - Reset then job t_start=0, t_final=5, sq_in=0x3 -> ap_start 1 cycle; beats 0,0,5,0,3,0..0;
//    tlast only on beat 35.
//  - m_axis_tready toggling 1/0 every cycle -> 36 beats, identical data order, no beat duplicated or lost.
//  - Result stream t=5, sq=0x9, tlast on beat 34 -> res_t=5, res_sq=0x9, res_err=0; res_valid is held until res_ready.
//  - Result tlast on beat 10 -> RESULT with res_err=2'b01 after 11 beats; s_axis_tready low afterwards.
//  - TIMEOUT_CYCLES=16, m_axis_tready held 0 -> res_valid with res_err=2'b10 on the 17th SEND cycle.
//  - reset asserted during RECV beat 20 -> IDLE, res_valid never high, next job runs cleanly.

Source files
------------

// File: rtl/msu_job_driver.sv
// Host-side job driver for the MSU stream engine: serializes a job, pulses ap_start,
// collects and frame-checks the result stream, then holds the result until consumed.
module msu_job_driver #(
  parameter int AXI_LEN        = 32,
  parameter int T_LEN          = 64,
  parameter int SQ_IN_BITS     = 1024,
  parameter int SQ_OUT_BITS    = 1056,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [T_LEN-1:0]         job_t_start,
  input  logic [T_LEN-1:0]         job_t_final,
  input  logic [SQ_IN_BITS-1:0]    job_sq_in,
  output logic                     ap_start,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [AXI_LEN-1:0]       m_axis_tdata,
  output logic [AXI_LEN/8-1:0]     m_axis_tkeep,
  output logic                     m_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [AXI_LEN-1:0]       s_axis_tdata,
  input  logic                     s_axis_tlast,
  input  logic                     ap_done,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [T_LEN-1:0]         res_t,
  output logic [SQ_OUT_BITS-1:0]   res_sq,
  output logic [1:0]               res_err
);

  localparam int IN_CNT  = 2*T_LEN/AXI_LEN + SQ_IN_BITS/AXI_LEN;
  localparam int OUT_CNT = T_LEN/AXI_LEN + SQ_OUT_BITS/AXI_LEN;
  localparam int IN_W    = 2*T_LEN + SQ_IN_BITS;
  localparam int OUT_W   = T_LEN + SQ_OUT_BITS;
  localparam int MAX_CNT = (IN_CNT > OUT_CNT) ? IN_CNT : OUT_CNT;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int TO_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND,
    S_RECV,
    S_RESULT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [IN_W-1:0]  in_q, in_d;
  logic [OUT_W-1:0] res_q, res_d;
  logic [1:0]       err_q, err_d;

  logic [OUT_W-1:0] rx_word;
  logic [TO_W-1:0]  to_inc;
  logic             tmo_hit;
  logic             tx_last;
  logic             rx_last;

  // ap_done is observed for debug visibility only; sequencing never waits on it
  logic unused_ap_done;
  assign unused_ap_done = ap_done;

  assign rx_word = {s_axis_tdata, res_q[OUT_W-1:AXI_LEN]};
  assign to_inc  = to_cnt_q + TO_W'(1);
  assign tmo_hit = (TIMEOUT_CYCLES > 0) && (to_inc == TO_W'(TIMEOUT_CYCLES));
  assign tx_last = (cnt_q == CNT_W'(IN_CNT - 1));
  assign rx_last = (cnt_q == CNT_W'(OUT_CNT - 1));

  assign job_ready     = (state_q == S_IDLE);
  assign ap_start      = (state_q == S_START);
  assign m_axis_tvalid = (state_q == S_SEND);
  assign m_axis_tdata  = in_q[AXI_LEN-1:0];
  assign m_axis_tkeep  = '1;
  assign m_axis_tlast  = (state_q == S_SEND) && tx_last;
  assign s_axis_tready = (state_q == S_RECV);
  assign res_valid     = (state_q == S_RESULT);
  assign res_t         = res_q[T_LEN-1:0];
  assign res_sq        = res_q[OUT_W-1:T_LEN];
  assign res_err       = err_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    to_cnt_d = to_cnt_q;
    in_d     = in_q;
    res_d    = res_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (job_valid) begin
          in_d    = {job_sq_in, job_t_final, job_t_start};
          res_d   = '0;
          err_d   = '0;
          state_d = S_START;
        end
      end

      S_START: state_d = S_SEND;

      S_SEND: begin
        if (m_axis_tready) begin
          in_d     = in_q >> AXI_LEN;
          cnt_d    = cnt_q + CNT_W'(1);
          to_cnt_d = '0;
          if (tx_last) begin
            cnt_d   = '0;
            state_d = S_RECV;
          end
        end else if (TIMEOUT_CYCLES > 0) begin
          to_cnt_d = to_inc;
          if (tmo_hit) begin
            err_d[1] = 1'b1;
            cnt_d    = '0;
            state_d  = S_RESULT;
          end
        end
      end

      S_RECV: begin
        if (s_axis_tvalid) begin
          res_d    = rx_word;
          cnt_d    = cnt_q + CNT_W'(1);
          to_cnt_d = '0;
          if (rx_last) begin
            err_d[0] = ~s_axis_tlast;
            cnt_d    = '0;
            state_d  = S_RESULT;
          end else if (s_axis_tlast) begin
            // short frame: slide the received words down so the first beat is the LSW
            res_d    = rx_word >> (AXI_LEN * (OUT_CNT - 1 - int'(cnt_q)));
            err_d[0] = 1'b1;
            cnt_d    = '0;
            state_d  = S_RESULT;
          end
        end else if (TIMEOUT_CYCLES > 0) begin
          to_cnt_d = to_inc;
          if (tmo_hit) begin
            err_d[1] = 1'b1;
            cnt_d    = '0;
            state_d  = S_RESULT;
          end
        end
      end

      S_RESULT: begin
        if (res_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) to_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      to_cnt_q <= '0;
      in_q     <= '0;
      res_q    <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      to_cnt_q <= to_cnt_d;
      in_q     <= in_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_msu_job_driver.sv
// Bench for msu_job_driver: random jobs and result streams checked against a word-list model.
module tb_msu_job_driver;

  localparam int TO = 16;

  logic          clk;
  logic          reset;
  logic          job_valid;
  logic          job_ready;
  logic [63:0]   job_t_start;
  logic [63:0]   job_t_final;
  logic [1023:0] job_sq_in;
  logic          ap_start;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [31:0]   m_axis_tdata;
  logic [3:0]    m_axis_tkeep;
  logic          m_axis_tlast;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [31:0]   s_axis_tdata;
  logic          s_axis_tlast;
  logic          ap_done;
  logic          res_valid;
  logic          res_ready;
  logic [63:0]   res_t;
  logic [1055:0] res_sq;
  logic [1:0]    res_err;

  msu_job_driver #(
    .AXI_LEN(32), .T_LEN(64), .SQ_IN_BITS(1024), .SQ_OUT_BITS(1056), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_t_start(job_t_start), .job_t_final(job_t_final), .job_sq_in(job_sq_in),
    .ap_start(ap_start),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast),
    .ap_done(ap_done),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_t(res_t), .res_sq(res_sq), .res_err(res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_in [36];
  logic [31:0] rx_w   [35];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1023:0] rand_sq();
    logic [1023:0] v;
    for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // tmode: 0 always ready, 1 toggling, 2 random; rx_dir: 1 = t=5 sq=9 result words
  task automatic run_job(input logic [63:0] ts, input logic [63:0] tf, input logic [1023:0] sq,
                         input int tmode, input int last_idx, input int rst_at, input int rx_dir);
    int beat;
    int guard;
    int run;
    int hold;
    logic tg;
    logic [1119:0] ev;
    logic [63:0] t_snap;

    for (int i = 0; i < 2; i++) begin
      exp_in[i]     = ts[i*32 +: 32];
      exp_in[2 + i] = tf[i*32 +: 32];
    end
    for (int i = 0; i < 32; i++) exp_in[4 + i] = sq[i*32 +: 32];
    for (int i = 0; i < 35; i++) rx_w[i] = rx_dir ? 32'd0 : $urandom;
    if (rx_dir) begin
      rx_w[0] = 32'd5;
      rx_w[2] = 32'd9;
    end

    guard = 0;
    while (!job_ready && guard < 100) begin
      step();
      guard++;
    end
    chk("job_ready", 64'(job_ready), 64'd1);
    job_valid   = 1'b1;
    job_t_start = ts;
    job_t_final = tf;
    job_sq_in   = sq;
    step();
    job_valid = 1'b0;
    chk("ap_start", 64'(ap_start), 64'd1);
    chk("start_tvalid", 64'(m_axis_tvalid), 64'd0);
    step();

    beat = 0; guard = 0; run = 0; tg = 1'b1;
    while (beat < 36 && guard < 1000) begin
      case (tmode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = tg;
        default: m_axis_tready = ($urandom_range(0, 3) != 0) || (run >= 8);
      endcase
      tg  = ~tg;
      run = m_axis_tready ? 0 : run + 1;
      chk("send_tvalid", 64'(m_axis_tvalid), 64'd1);
      chk("send_ap_start", 64'(ap_start), 64'd0);
      chk("send_s_tready", 64'(s_axis_tready), 64'd0);
      chk($sformatf("tdata[%0d]", beat), 64'(m_axis_tdata), 64'(exp_in[beat]));
      chk($sformatf("tlast[%0d]", beat), 64'(m_axis_tlast), 64'(beat == 35));
      if (m_axis_tvalid && m_axis_tready) beat++;
      step();
      guard++;
    end
    m_axis_tready = 1'b0;
    chk("send_beats", 64'(beat), 64'd36);
    chk("recv_m_tvalid", 64'(m_axis_tvalid), 64'd0);

    beat = 0; guard = 0; run = 0;
    while (beat <= last_idx && guard < 1000) begin
      if (rst_at >= 0 && beat == rst_at) begin
        reset         = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = rx_w[beat];
        s_axis_tlast  = 1'b0;
        step();
        break;
      end
      s_axis_tvalid = ($urandom_range(0, 3) != 0) || (run >= 8);
      run           = s_axis_tvalid ? 0 : run + 1;
      s_axis_tdata  = rx_w[beat];
      s_axis_tlast  = (beat == last_idx);
      chk("recv_s_tready", 64'(s_axis_tready), 64'd1);
      if (s_axis_tvalid && s_axis_tready) beat++;
      step();
      guard++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;

    if (rst_at >= 0) begin
      chk("rst_job_ready", 64'(job_ready), 64'd1);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
      chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      reset = 1'b1;
      for (int c = 0; c < 5; c++) begin
        step();
        chk("post_rst_res_valid", 64'(res_valid), 64'd0);
        chk("post_rst_ap_start", 64'(ap_start), 64'd0);
      end
      return;
    end

    chk("recv_beats", 64'(beat), 64'(last_idx + 1));
    ev = '0;
    for (int i = 0; i <= last_idx; i++) ev[i*32 +: 32] = rx_w[i];
    chk("res_valid", 64'(res_valid), 64'd1);
    chk("res_s_tready", 64'(s_axis_tready), 64'd0);
    chk("res_err", 64'(res_err), (last_idx == 34) ? 64'd0 : 64'd1);
    chk("res_t", res_t, ev[63:0]);
    for (int i = 0; i < 33; i++)
      chk($sformatf("res_sq[%0d]", i), 64'(res_sq[i*32 +: 32]), 64'(ev[64 + i*32 +: 32]));

    t_snap    = ev[63:0];
    hold      = $urandom_range(1, 3);
    job_valid = 1'b1;
    for (int c = 0; c < hold; c++) begin
      step();
      chk("hold_res_valid", 64'(res_valid), 64'd1);
      chk("hold_res_t", res_t, t_snap);
      chk("hold_job_ready", 64'(job_ready), 64'd0);
      chk("hold_ap_start", 64'(ap_start), 64'd0);
    end
    job_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("done_res_valid", 64'(res_valid), 64'd0);
    chk("done_job_ready", 64'(job_ready), 64'd1);
  endtask

  task automatic run_timeout(input logic [63:0] ts);
    int cycles;
    guard_wait: begin
    end
    job_valid   = 1'b1;
    job_t_start = ts;
    job_t_final = 64'd0;
    job_sq_in   = '0;
    m_axis_tready = 1'b0;
    step();
    job_valid = 1'b0;
    chk("to_ap_start", 64'(ap_start), 64'd1);
    step();
    cycles = 0;
    while (m_axis_tvalid && cycles < 40) begin
      chk("to_tdata", 64'(m_axis_tdata), 64'(ts[31:0]));
      cycles++;
      step();
    end
    chk("to_send_cycles", 64'(cycles), 64'(TO));
    chk("to_res_valid", 64'(res_valid), 64'd1);
    chk("to_res_err", 64'(res_err), 64'd2);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("to_done_job_ready", 64'(job_ready), 64'd1);
  endtask

  initial begin
    reset         = 1'b0;
    job_valid     = 1'b0;
    job_t_start   = '0;
    job_t_final   = '0;
    job_sq_in     = '0;
    m_axis_tready = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    ap_done       = 1'b0;
    res_ready     = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
    chk("rst_job_ready", 64'(job_ready), 64'd1);
    chk("rst_ap_start", 64'(ap_start), 64'd0);
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_err", 64'(res_err), 64'd0);
    chk("tkeep", 64'(m_axis_tkeep), 64'hF);

    run_job(64'd0, 64'd5, 1024'h3, 0, 34, -1, 1);
    run_job({$urandom, $urandom}, {$urandom, $urandom}, rand_sq(), 1, 34, -1, 0);
    run_job({$urandom, $urandom}, {$urandom, $urandom}, rand_sq(), 2, 10, -1, 0);
    run_timeout({$urandom, $urandom});
    run_job({$urandom, $urandom}, {$urandom, $urandom}, rand_sq(), 0, 34, 20, 0);
    run_job({$urandom, $urandom}, {$urandom, $urandom}, rand_sq(), 2, 34, -1, 0);
    for (int j = 0; j < 6; j++)
      run_job({$urandom, $urandom}, {$urandom, $urandom}, rand_sq(), int'($urandom_range(0, 2)),
              (j % 2 == 0) ? 34 : int'($urandom_range(0, 33)), -1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
